// File: rtl/ysyx_23060332_dmem_resp_pkg.sv
// Shared encodings and constants for the data-memory responder.
package ysyx_23060332_dmem_resp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [7:0]  MASK_B       = 8'h01;
    localparam logic [7:0]  MASK_H       = 8'h03;
    localparam logic [7:0]  MASK_W       = 8'h0F;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    // Store width in bytes for a legal mask, 0 for anything else.
    function automatic logic [2:0] mask_bytes(input logic [7:0] m);
        case (m)
            MASK_B:  return 3'd1;
            MASK_H:  return 3'd2;
            MASK_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060332_sram_bank.sv
// Single-port synchronous word array with byte enables and a registered read port.
module ysyx_23060332_sram_bank #(
    parameter int unsigned AW = 12
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_23060332_dmem_resp.sv
// Load/store responder: accepts one request, waits LATENCY cycles, accesses the
// bank with lane alignment and holds the response until the consumer takes it.
module ysyx_23060332_dmem_resp
    import ysyx_23060332_dmem_resp_pkg::*;
#(
    parameter logic [31:0] BASE       = DEFAULT_BASE,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [3:0]  LatInit = 4'(LATENCY - 1);
    localparam logic [32:0] Span    = 33'd4 << DEPTH_LOG2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rd_ok_q, rd_ok_d;

    logic [31:0] off_addr;
    logic        in_range;
    logic [1:0]  lane;
    logic [2:0]  nbytes;
    logic        store_bad;
    logic        acc_err;
    logic        access;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] bank_rdata;

    // Decode and alignment checks operate on the latched request.
    always_comb begin
        off_addr  = addr_q - BASE;
        in_range  = (addr_q >= BASE) && ({1'b0, off_addr} < Span);
        lane      = addr_q[1:0];
        nbytes    = mask_bytes(wmask_q);
        store_bad = (nbytes == 3'd0) || (({1'b0, lane} + nbytes) > 3'd4);
        acc_err   = !in_range || (wen_q && store_bad);
        access    = (state_q == StBusy) && (cnt_q == 4'd0);
        be        = wmask_q[3:0] << lane;
        wdata_sh  = wdata_q << {lane, 3'b000};
    end

    ysyx_23060332_sram_bank #(
        .AW (DEPTH_LOG2)
    ) u_bank (
        .clk_i   (clk_i),
        .en_i    (access && !acc_err),
        .we_i    (wen_q),
        .be_i    (be),
        .addr_i  (off_addr[DEPTH_LOG2+1:2]),
        .wdata_i (wdata_sh),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_ok_d     = rd_ok_q;
        req_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    wen_d   = req_wen_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wmask_d = req_wmask_i;
                    cnt_d   = LatInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rd_ok_d     = !acc_err && !wen_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_ok_d     = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            wen_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wmask_q     <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    // The bank's read register holds until the next access, so the shifted word
    // stays stable through RESP; rd_ok_q forces zero for stores and errors.
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_ok_q ? (bank_rdata >> {lane, 3'b000}) : 32'd0;

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Drives three responders (LATENCY 2, 1, 15) against a byte-addressed memory model.
module tb_ysyx_23060332_dmem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic [31:0] rsp_rdata [3];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mm [bit [63:0]];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_23060332_dmem_resp #(
            .BASE       (BASE),
            .DEPTH_LOG2 (12),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_wen_i   (req_wen[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_wmask_i (req_wmask[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, i, $time, act, exp);
        end
    endtask

    // Memory modelled as individual bytes; a store is a list of byte writes and a
    // load gathers the bytes from addr upward, zero above the top of the word.
    function automatic void model(input int i, input bit wen, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [7:0] wm,
                                  output logic [31:0] rd, output logic err);
        longint unsigned ua = 64'(a);
        int off = int'(a[1:0]);
        int n;
        bit inr = (ua >= 64'h8000_0000) && (ua < 64'h8000_0000 + 64'd16384);
        rd  = 32'd0;
        err = 1'b0;
        if (!inr) begin
            err = 1'b1;
        end else if (wen) begin
            n = (wm == 8'h01) ? 1 : (wm == 8'h03) ? 2 : (wm == 8'h0F) ? 4 : 0;
            if (n == 0 || off + n > 4) err = 1'b1;
            else for (int b = 0; b < n; b++) mm[{32'(i), a + 32'(b)}] = wd[8*b +: 8];
        end else begin
            for (int k = 0; k < 4 - off; k++) rd[8*k +: 8] = mm[{32'(i), a + 32'(k)}];
        end
    endfunction

    task automatic drive_junk(input int i);
        req_valid[i] = 1'($urandom);
        req_wen[i]   = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_wmask[i] = 8'($urandom);
    endtask

    task automatic wait_ready(input int i);
        int w = 0;
        while (!req_ready[i] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready[i]) chk("ready_timeout", i, 32'(req_ready[i]), 32'd1);
    endtask

    task automatic txn(input int i, input bit wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [7:0] wm, input int hold,
                       output logic [31:0] got_rd, output logic got_err);
        logic [31:0] erd;
        logic        eerr;
        int          lat = lat_of(i);
        wait_ready(i);
        model(i, wen, a, wd, wm, erd, eerr);
        req_valid[i] = 1'b1;
        req_wen[i]   = wen;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_wmask[i] = wm;
        @(posedge clk); #1;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk("busy_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("busy_req_ready", i, 32'(req_ready[i]), 32'd0);
            drive_junk(i);
            rsp_ready[i] = 1'($urandom);
        end
        @(posedge clk); #1;
        chk("rsp_valid_at_latency", i, 32'(rsp_valid[i]), 32'd1);
        chk("rsp_rdata", i, rsp_rdata[i], erd);
        chk("rsp_err", i, 32'(rsp_err[i]), 32'(eerr));
        got_rd  = rsp_rdata[i];
        got_err = rsp_err[i];
        for (int h = 0; h < hold; h++) begin
            rsp_ready[i] = 1'b0;
            drive_junk(i);
            @(posedge clk); #1;
            chk("hold_rsp_valid", i, 32'(rsp_valid[i]), 32'd1);
            chk("hold_rsp_rdata", i, rsp_rdata[i], erd);
            chk("hold_rsp_err", i, 32'(rsp_err[i]), 32'(eerr));
            chk("hold_req_ready", i, 32'(req_ready[i]), 32'd0);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        req_valid[i] = 1'b0;
        chk("post_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
        chk("post_req_ready", i, 32'(req_ready[i]), 32'd1);
    endtask

    // Reset between accept and access edge: the store must be lost.
    task automatic rst_store(input int i);
        wait_ready(i);
        req_valid[i] = 1'b1;
        req_wen[i]   = 1'b1;
        req_addr[i]  = 32'h8000_0020;
        req_wdata[i] = 32'h1234_5678;
        req_wmask[i] = 8'h0F;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (lat_of(i) >= 2) begin
            @(posedge clk); #1;
        end
        rst[i] = 1'b1;
        #1;
        chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
        chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
        @(posedge clk); #1;
        rst[i] = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
    endtask

    task automatic directed(input int i);
        logic [31:0] rd;
        logic        er;
        txn(i, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, rd, er);
        chk("t1_sw_err", i, 32'(er), 32'd0);
        txn(i, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er);
        chk("t1_lw", i, rd, 32'hDEAD_BEEF);
        txn(i, 1'b1, 32'h8000_0013, 32'h0000_0055, 8'h01, 0, rd, er);
        txn(i, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er);
        chk("t2_lw", i, rd, 32'h55AD_BEEF);
        txn(i, 1'b1, 32'h8000_0013, 32'h0000_AAAA, 8'h03, 0, rd, er);
        chk("t3_sh_cross_err", i, 32'(er), 32'd1);
        txn(i, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er);
        chk("t3_unchanged", i, rd, 32'h55AD_BEEF);
        txn(i, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, 0, rd, er);
        chk("t4_low_err", i, {31'd0, er}, 32'd1);
        chk("t4_low_rdata", i, rd, 32'd0);
        txn(i, 1'b0, 32'h8001_0000, 32'h0, 8'h0, 0, rd, er);
        chk("t4_high_err", i, {31'd0, er}, 32'd1);
        txn(i, 1'b0, 32'h8000_4000, 32'h0, 8'h0, 0, rd, er);
        chk("t4_end_err", i, {31'd0, er}, 32'd1);
        txn(i, 1'b1, 32'h8000_3FFC, 32'h0BAD_CAFE, 8'h0F, 0, rd, er);
        txn(i, 1'b0, 32'h8000_3FFD, 32'h0, 8'h0, 0, rd, er);
        chk("t4_last_word", i, rd, 32'h000B_ADCA);
        txn(i, 1'b0, 32'h8000_0012, 32'h0, 8'h0, 0, rd, er);
        chk("t4_lw_offset2", i, rd, 32'h0000_55AD);
        txn(i, 1'b1, 32'h8000_0010, 32'h0, 8'h07, 0, rd, er);
        chk("bad_mask_err", i, {31'd0, er}, 32'd1);
        txn(i, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 5, rd, er);
        chk("t5_hold_lw", i, rd, 32'h55AD_BEEF);
        txn(i, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 8'h0F, 0, rd, er);
        rst_store(i);
        txn(i, 1'b0, 32'h8000_0020, 32'h0, 8'h0, 0, rd, er);
        chk("t6_prior_value", i, rd, 32'hCAFE_F00D);
    endtask

    task automatic random_run(input int i, input int n);
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [7:0]  wm;
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h7FFF_FFFC;
                    1:       a = 32'h8000_4000;
                    2:       a = 32'h0000_0000;
                    default: a = 32'hFFFF_FFFD;
                endcase
            end else begin
                a = BASE + 32'($urandom_range(0, 63));
            end
            case ($urandom_range(0, 3))
                0:       wm = 8'h01;
                1:       wm = 8'h03;
                2:       wm = 8'h0F;
                default: wm = 8'($urandom);
            endcase
            txn(i, 1'($urandom), a, $urandom, wm, $urandom_range(0, 3), rd, er);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        rst       = 3'b111;
        req_valid = '0;
        req_wen   = '0;
        rsp_ready = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_wmask[i] = '0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("reset_rsp_rdata", i, rsp_rdata[i], 32'd0);
            chk("reset_rsp_err", i, 32'(rsp_err[i]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) chk("reset_req_ready", i, 32'(req_ready[i]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 16; w++) begin
                txn(i, 1'b1, BASE + 32'(4 * w), $urandom, 8'h0F, 0, rd, er);
            end
            directed(i);
            random_run(i, (i == 2) ? 40 : 120);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
